eth_decap_core: RTL
===================

# eth_decap_core

Receive-side NetTLP decapsulator. It sits between the 64-bit Ethernet RX AXI-Stream from the MAC and the three RX FIFOs: TLP, NetTLP command, and PCIe config. It parses the Ethernet/IPv4/UDP/NetTLP header, filters and classifies each frame by UDP destination port, strips the header, and writes the payload into the matching FIFO. The framing and byte order are exactly those produced by `eth_encap_core` on the TX side.

## Interface

**Parameters**
- `udp_port_mr`, 16'h3000: base of the MemRd/MemWr port range, 16 ports.
- `udp_port_cpl`, 16'h4000: base of the completion port range, 256 ports.
- `udp_port_cmd`, 16'h3100: NetTLP command port.
- `udp_port_cfg`, 16'h3200: PCIe config port.

**Ports**
- `eth_clk` in 1: clock.
- `eth_rst_n` in 1: asynchronous, active-low reset.
- `eth_tvalid` in 1, `eth_tready` out 1, `eth_tdata` in 64, `eth_tkeep` in 8, `eth_tlast` in 1, `eth_tuser` in 1: MAC RX stream. `eth_tuser` marks a bad frame and is sampled on `tlast`.
- `adapter_reg_srcmac` in 48, `adapter_reg_srcip` in 32: local MAC and IP.
- `tlp_wr_en` out 1, `tlp_din` out 74 = {err, tlast, keep[7:0], data[63:0]}, `tlp_full` in 1.
- `cmd_wr_en` out 1, `cmd_din` out 64, `cmd_full` in 1.
- `cfg_wr_en` out 1, `cfg_din` out 64, `cfg_full` in 1.
- `rx_seq` out 16, `rx_tstamp` out 32: NetTLP header fields of the last accepted TLP frame.
- `rx_drop_cnt` out 32, `rx_err_cnt` out 32: statistics counters.

## Operation

**Byte and beat layout**
- Wire byte i of a frame is in beat i/8, at `eth_tdata[8*(i%8)+:8]`. Multi-byte header fields are big-endian.

**Per-beat checks (beat counter `bc`, 3 bits)**
- bc=0: bytes 0–5 must equal `adapter_reg_srcmac` or FF:FF:FF:FF:FF:FF.
- bc=1: bytes 12–13 must be 16'h0800 and byte 14 must be 8'h45.
- bc=2: byte 23 must be 8'h11.
- bc=3: bytes 30–31 must equal `srcip[31:16]`.
- bc=4: bytes 32–33 must equal `srcip[15:0]`. Bytes 36–37 are the destination port `dport`.
  - Classification priority: `dport==cmd` gives CMD; `dport==cfg` gives CFG; `dport-mr<16` or `dport-cpl<256` (16-bit unsigned subtraction) gives TLP; anything else fails.
- Failure flags accumulate in a sticky register. At bc=4, any failure sends the FSM to S_DROP, or to S_HDR if the beat carries `tlast`.

**States**
- **S_HDR** (reset state): accepts beats 0–4.
  - `tlast` on any of these beats: drop the frame, `rx_drop_cnt`++, stay in S_HDR with bc=0.
  - At bc=4 with all checks passing: go to S_NTHDR, S_CMD or S_CFG by class.
- **S_NTHDR**: beat 5 of a TLP frame.
  - Capture `rx_seq` = bytes 42–43 and `rx_tstamp` = bytes 44–47. Go to S_TLP.
  - `tlast` here: drop the frame and count it.
- **S_TLP**: beat 6 onward.
  - Each accepted beat writes `tlp_din`.
    - data: bytes reversed within each 32-bit dword, i.e. out[31:0] = {b0,b1,b2,b3}, out[63:32] = {b4,b5,b6,b7}.
    - keep: 8'hFF if `|eth_tkeep[7:4]`, else 8'h0F.
    - tlast: `eth_tlast`.
    - err: `eth_tuser & eth_tlast`.
  - On `tlast`: `rx_err_cnt`++ if err is set, then go to S_HDR.
- **S_CMD / S_CFG**: beat 5 is the payload qword.
  - Write `*_din` = full 64-bit byte reversal of `eth_tdata` only if `tlast`=1 and `tuser`=0. Otherwise: `tuser`=1 gives `rx_err_cnt`++; no `tlast` gives `rx_drop_cnt`++ and S_DROP. No write in either case.
  - With `tlast` present, go to S_HDR.
- **S_DROP**: consume beats until `tlast`, then go to S_HDR.

**Counters**
- Both counters wrap at 2^32.

## Timing

**Reset values**
- While `eth_rst_n`=0, every output is 0 and the FSM is in S_HDR with bc=0 and flags clear.
- Reset asserted mid-frame: the remainder of that frame is parsed as a new header, fails the MAC or ethertype check, and is dropped and counted.

**Ready rules**
- `eth_tready` (0 in reset): 1 in S_HDR, S_NTHDR and S_DROP; `!tlp_full` in S_TLP; `!cmd_full` in S_CMD; `!cfg_full` in S_CFG.
- `eth_tready` never depends on `eth_tvalid`.

**Write timing**
- FIFO writes are combinational pass-through, with zero latency from the accepted beat.
- `*_wr_en` = `eth_tvalid & eth_tready` & (state condition).
- A `*_wr_en` never asserts while the corresponding `*_full` is high.

**Update timing**
- The state and bc advance only on accepted beats (`tvalid & tready`).
- Counters, `rx_seq` and `rx_tstamp` update on the clock edge after the accepting beat.

**Throughput**
- One beat per cycle; back-to-back frames with no idle cycles are accepted.

## Test plan

1. **Basic TLP.** Frame to `srcmac`, dport 16'h3005, seq 16'h0102, three TLP qwords, the last with keep 8'h0F. Expect three `tlp_wr_en` pulses with dword-byte-swapped data, last beat tlast=1 and keep=8'h0F, and `rx_seq`=16'h0102.
2. **Command frame.** Broadcast MAC, dport 16'h3100, beat 5 = 64'h0807060504030201 with `tlast`. Expect one `cmd_din`=64'h0102030405060708 and no TLP write.
3. **Filter misses.** Wrong destination MAC; IP protocol 8'h06; dport 16'h5000. Each case: no writes, `rx_drop_cnt` increments by one, `eth_tready` stays 1.
4. **Backpressure.** Raise `tlp_full` for 4 cycles mid-payload. Expect `eth_tready`=0 with no writes while full, then every payload beat written exactly once, in order.
5. **Runt frame.** `tlast` at beat 3, followed immediately by a valid completion frame to dport 16'h40A7. Expect the runt counted as a drop and the second frame written to the TLP FIFO.
6. **Error and reset.** TLP frame with `tuser`=1 on its last beat: err=1 on the last write, `rx_err_cnt`=1. Then assert `eth_rst_n` low mid-frame: all outputs go to 0 and the next full frame decodes correctly.

Source files
------------

// File: rtl/eth_decap_core.sv
// Receive-side NetTLP decapsulator: parses Eth/IPv4/UDP/NetTLP headers, filters on
// destination MAC/IP/UDP port and steers the payload into the TLP, CMD or CFG FIFO.
module eth_decap_core #(
  parameter logic [15:0] udp_port_mr  = 16'h3000,
  parameter logic [15:0] udp_port_cpl = 16'h4000,
  parameter logic [15:0] udp_port_cmd = 16'h3100,
  parameter logic [15:0] udp_port_cfg = 16'h3200
) (
  input  logic        eth_clk,
  input  logic        eth_rst_n,
  input  logic        eth_tvalid,
  output logic        eth_tready,
  input  logic [63:0] eth_tdata,
  input  logic [7:0]  eth_tkeep,
  input  logic        eth_tlast,
  input  logic        eth_tuser,
  input  logic [47:0] adapter_reg_srcmac,
  input  logic [31:0] adapter_reg_srcip,
  output logic        tlp_wr_en,
  output logic [73:0] tlp_din,
  input  logic        tlp_full,
  output logic        cmd_wr_en,
  output logic [63:0] cmd_din,
  input  logic        cmd_full,
  output logic        cfg_wr_en,
  output logic [63:0] cfg_din,
  input  logic        cfg_full,
  output logic [15:0] rx_seq,
  output logic [31:0] rx_tstamp,
  output logic [31:0] rx_drop_cnt,
  output logic [31:0] rx_err_cnt
);

  typedef enum logic [2:0] {S_HDR, S_NTHDR, S_TLP, S_CMD, S_CFG, S_DROP} state_t;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  state_t      state_q, state_d;
  logic [2:0]  bc_q, bc_d;
  logic        fail_q, fail_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] tstamp_q, tstamp_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  logic [7:0]  b0, b1, b2, b3, b4, b5, b6, b7;
  logic [15:0] dport, d_mr, d_cpl;
  logic        is_cmd, is_cfg, is_tlp, beat_fail;
  logic        rdy, accept, tlp_wr, cmd_wr, cfg_wr, tlp_err;
  logic        unused_keep_lo;

  // Wire byte i of a beat sits at eth_tdata[8*i +: 8].
  assign b0 = eth_tdata[7:0];
  assign b1 = eth_tdata[15:8];
  assign b2 = eth_tdata[23:16];
  assign b3 = eth_tdata[31:24];
  assign b4 = eth_tdata[39:32];
  assign b5 = eth_tdata[47:40];
  assign b6 = eth_tdata[55:48];
  assign b7 = eth_tdata[63:56];

  assign unused_keep_lo = ^eth_tkeep[3:0];

  assign dport  = {b4, b5};
  assign d_mr   = dport - udp_port_mr;
  assign d_cpl  = dport - udp_port_cpl;
  assign is_cmd = (dport == udp_port_cmd);
  assign is_cfg = (dport == udp_port_cfg);
  assign is_tlp = (d_mr < 16'd16) || (d_cpl < 16'd256);

  always_comb begin
    beat_fail = 1'b0;
    case (bc_q)
      3'd0: beat_fail = ({b0, b1, b2, b3, b4, b5} != adapter_reg_srcmac) &&
                        ({b0, b1, b2, b3, b4, b5} != BCAST_MAC);
      3'd1: beat_fail = ({b4, b5} != 16'h0800) || (b6 != 8'h45);
      3'd2: beat_fail = (b7 != 8'h11);
      3'd3: beat_fail = ({b6, b7} != adapter_reg_srcip[31:16]);
      3'd4: beat_fail = ({b0, b1} != adapter_reg_srcip[15:0]) || !(is_cmd || is_cfg || is_tlp);
      default: beat_fail = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bc_d       = bc_q;
    fail_d     = fail_q;
    seq_d      = seq_q;
    tstamp_d   = tstamp_q;
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    tlp_wr     = 1'b0;
    cmd_wr     = 1'b0;
    cfg_wr     = 1'b0;

    case (state_q)
      S_TLP:   rdy = !tlp_full;
      S_CMD:   rdy = !cmd_full;
      S_CFG:   rdy = !cfg_full;
      default: rdy = 1'b1;
    endcase
    rdy    = rdy & eth_rst_n;
    accept = eth_tvalid & rdy;

    if (accept) begin
      case (state_q)
        S_HDR: begin
          if (eth_tlast) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            bc_d       = 3'd0;
            fail_d     = 1'b0;
          end else if (bc_q == 3'd4) begin
            bc_d   = 3'd0;
            fail_d = 1'b0;
            if (fail_q || beat_fail) begin
              drop_cnt_d = drop_cnt_q + 32'd1;
              state_d    = S_DROP;
            end else if (is_cmd) begin
              state_d = S_CMD;
            end else if (is_cfg) begin
              state_d = S_CFG;
            end else begin
              state_d = S_NTHDR;
            end
          end else begin
            bc_d   = bc_q + 3'd1;
            fail_d = fail_q | beat_fail;
          end
        end
        S_NTHDR: begin
          if (eth_tlast) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = S_HDR;
          end else begin
            seq_d    = {b2, b3};
            tstamp_d = {b4, b5, b6, b7};
            state_d  = S_TLP;
          end
        end
        S_TLP: begin
          tlp_wr = 1'b1;
          if (eth_tlast) begin
            if (eth_tuser) err_cnt_d = err_cnt_q + 32'd1;
            state_d = S_HDR;
          end
        end
        S_CMD, S_CFG: begin
          // The command/config payload is exactly one qword; anything longer is dropped.
          if (eth_tlast) begin
            if (eth_tuser) err_cnt_d = err_cnt_q + 32'd1;
            else if (state_q == S_CMD) cmd_wr = 1'b1;
            else cfg_wr = 1'b1;
            state_d = S_HDR;
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = S_DROP;
          end
        end
        S_DROP: begin
          if (eth_tlast) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge eth_clk or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q    <= S_HDR;
      bc_q       <= 3'd0;
      fail_q     <= 1'b0;
      seq_q      <= 16'd0;
      tstamp_q   <= 32'd0;
      drop_cnt_q <= 32'd0;
      err_cnt_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      bc_q       <= bc_d;
      fail_q     <= fail_d;
      seq_q      <= seq_d;
      tstamp_q   <= tstamp_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign tlp_err    = eth_tuser & eth_tlast;
  assign eth_tready = rdy;
  assign tlp_wr_en  = tlp_wr;
  assign cmd_wr_en  = cmd_wr;
  assign cfg_wr_en  = cfg_wr;
  assign tlp_din    = tlp_wr ? {tlp_err, eth_tlast, (|eth_tkeep[7:4]) ? 8'hFF : 8'h0F,
                                b4, b5, b6, b7, b0, b1, b2, b3} : 74'd0;
  assign cmd_din    = cmd_wr ? {b0, b1, b2, b3, b4, b5, b6, b7} : 64'd0;
  assign cfg_din    = cfg_wr ? {b0, b1, b2, b3, b4, b5, b6, b7} : 64'd0;
  assign rx_seq      = seq_q;
  assign rx_tstamp   = tstamp_q;
  assign rx_drop_cnt = drop_cnt_q;
  assign rx_err_cnt  = err_cnt_q;

endmodule
